// File: rtl/mic1_uart_io.sv
// Memory-mapped 8N1 UART for the mic1 SoC: RX bytes land in a small FIFO popped by
// reads of IO_ADDR, writes of IO_ADDR are serialised on ser_tx. Define MIC1_UART_LOOPBACK_EN to feed ser_tx back into RX.
module mic1_uart_io #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter logic [31:0] IO_ADDR      = 32'hFFFF_FFFD,
  parameter logic [31:0] STAT_ADDR    = 32'hFFFF_FFFC,
  parameter int unsigned RX_DEPTH     = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ser_rx,
  output logic        ser_tx,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic        io_sel,
  output logic [31:0] io_rdata,
  output logic        rx_irq
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(RX_DEPTH);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [AW:0]   FIFO_FULL = (AW + 1)'(RX_DEPTH);

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

  // Bus decode
  logic is_io, is_stat, io_read, stat_read, io_write;
  assign is_io     = (mem_addr == IO_ADDR);
  assign is_stat   = (mem_addr == STAT_ADDR);
  assign io_sel    = is_io | is_stat;
  assign io_read   = mem_read & is_io;
  assign stat_read = mem_read & is_stat;
  assign io_write  = mem_write & is_io;

  logic unused_wdata;
  assign unused_wdata = &{1'b0, mem_wdata[31:8]};

  logic rx_in;
`ifdef MIC1_UART_LOOPBACK_EN
  logic unused_ser_rx;
  assign unused_ser_rx = ser_rx;
  assign rx_in = ser_tx;
`else
  assign rx_in = ser_rx;
`endif

  logic rx_meta, rx_sync, rx_sync_d;
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rx_meta   <= 1'b1;
      rx_sync   <= 1'b1;
      rx_sync_d <= 1'b1;
    end else begin
      rx_meta   <= rx_in;
      rx_sync   <= rx_meta;
      rx_sync_d <= rx_sync;
    end
  end

  // ---------------- RX FSM ----------------
  rx_state_t       rx_state, rx_next;
  logic [CW-1:0]   rx_cnt;
  logic [2:0]      rx_bit;
  logic [7:0]      rx_shift;
  logic            rx_push_req, frame_err_set;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) rx_state <= RX_IDLE;
    else         rx_state <= rx_next;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    rx_next       = rx_state;
    rx_push_req   = 1'b0;
    frame_err_set = 1'b0;
    case (rx_state)
      RX_IDLE:      if (rx_sync_d && !rx_sync) rx_next = RX_START;
      RX_START:     if (rx_cnt == HALF_LAST) rx_next = rx_sync ? RX_IDLE : RX_DATA;
      RX_DATA:      if (rx_cnt == BIT_LAST && rx_bit == 3'd7) rx_next = RX_STOP;
      RX_STOP:
        if (rx_cnt == BIT_LAST) begin
          if (rx_sync) begin
            rx_push_req = 1'b1;
            rx_next     = RX_IDLE;
          end else begin
            frame_err_set = 1'b1;
            rx_next       = RX_WAIT_HIGH;
          end
        end
      RX_WAIT_HIGH: if (rx_sync) rx_next = RX_IDLE;
      default:      rx_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      case (rx_state)
        RX_START: rx_cnt <= (rx_cnt == HALF_LAST) ? '0 : rx_cnt + CW'(1);
        RX_DATA:
          if (rx_cnt == BIT_LAST) begin
            rx_cnt   <= '0;
            rx_bit   <= rx_bit + 3'd1;
            rx_shift <= {rx_sync, rx_shift[7:1]};
          end else begin
            rx_cnt <= rx_cnt + CW'(1);
          end
        RX_STOP:  rx_cnt <= rx_cnt + CW'(1);
        default: begin
          rx_cnt <= '0;
          rx_bit <= '0;
        end
      endcase
    end
  end

  // ---------------- RX FIFO ----------------
  logic [7:0]    fifo_mem [RX_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   rx_count;
  logic          rx_avail, rx_full, pop, push, rx_overrun_set;

  assign rx_avail       = (rx_count != '0);
  assign rx_full        = (rx_count == FIFO_FULL);
  assign pop            = io_read & rx_avail;
  assign push           = rx_push_req & (~rx_full | pop);
  assign rx_overrun_set = rx_push_req & rx_full & ~pop;
  assign rx_irq         = rx_avail;

  // NOTE: the storage array is deliberately not reset; the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= rx_shift;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      rx_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   rx_count <= rx_count + (AW + 1)'(1);
        2'b01:   rx_count <= rx_count - (AW + 1)'(1);
        default: rx_count <= rx_count;
      endcase
    end
  end

  // ---------------- TX path ----------------
  tx_state_t     tx_state, tx_next;
  logic [CW-1:0] tx_cnt;
  logic [2:0]    tx_bit;
  logic [7:0]    tx_shift, hold_data;
  logic          hold_full, tx_load, tx_bit_end, tx_overrun_set;

  assign tx_bit_end     = (tx_cnt == BIT_LAST);
  assign tx_overrun_set = io_write & hold_full;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) tx_state <= TX_IDLE;
    else         tx_state <= tx_next;
  end

  // STOP hands straight over to START when a byte is waiting, so frames run gap-free.
  always_comb begin
    tx_next = tx_state;
    tx_load = 1'b0;
    case (tx_state)
      TX_IDLE:  if (hold_full) begin tx_next = TX_START; tx_load = 1'b1; end
      TX_START: if (tx_bit_end) tx_next = TX_DATA;
      TX_DATA:  if (tx_bit_end && tx_bit == 3'd7) tx_next = TX_STOP;
      TX_STOP:
        if (tx_bit_end) begin
          tx_next = TX_IDLE;
          if (hold_full) begin tx_next = TX_START; tx_load = 1'b1; end
        end
      default:  tx_next = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      ser_tx   <= 1'b1;
    end else if (tx_load) begin
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= hold_data;
      ser_tx   <= 1'b0;
    end else begin
      case (tx_state)
        TX_START:
          if (tx_bit_end) begin
            tx_cnt <= '0;
            ser_tx <= tx_shift[0];
          end else tx_cnt <= tx_cnt + CW'(1);
        TX_DATA:
          if (tx_bit_end) begin
            tx_cnt   <= '0;
            tx_bit   <= tx_bit + 3'd1;
            tx_shift <= {1'b0, tx_shift[7:1]};
            ser_tx   <= (tx_bit == 3'd7) ? 1'b1 : tx_shift[1];
          end else tx_cnt <= tx_cnt + CW'(1);
        TX_STOP:  tx_cnt <= tx_bit_end ? '0 : tx_cnt + CW'(1);
        default: begin
          tx_cnt <= '0;
          ser_tx <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hold_data <= '0;
      hold_full <= 1'b0;
    end else if (io_write && !hold_full) begin
      hold_data <= mem_wdata[7:0];
      hold_full <= 1'b1;
    end else if (tx_load) begin
      hold_full <= 1'b0;
    end
  end

  // ---------------- Status and read data ----------------
  logic frame_err, tx_overrun, rx_overrun;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      frame_err  <= 1'b0;
      tx_overrun <= 1'b0;
      rx_overrun <= 1'b0;
      io_rdata   <= '0;
    end else begin
      frame_err  <= frame_err_set  | (frame_err  & ~stat_read);
      tx_overrun <= tx_overrun_set | (tx_overrun & ~stat_read);
      rx_overrun <= rx_overrun_set | (rx_overrun & ~stat_read);
      if (io_read)
        io_rdata <= rx_avail ? {24'h0, fifo_mem[rd_ptr]} : 32'h0;
      else if (stat_read)
        io_rdata <= {27'h0, frame_err, tx_overrun, rx_overrun, ~hold_full, rx_avail};
    end
  end

endmodule

// File: tb/tb_mic1_uart_io.sv
// Directed bench for mic1_uart_io: RX FIFO, TX framing, status flags, overruns and reset.
module tb_mic1_uart_io;

  localparam logic [31:0] IO_ADDR   = 32'hFFFF_FFFD;
  localparam logic [31:0] STAT_ADDR = 32'hFFFF_FFFC;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        ser_rx = 1'b1;
  logic        ser_tx;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic        io_sel;
  logic [31:0] io_rdata;
  logic        rx_irq;

  int n_vec = 0;
  int n_err = 0;

  mic1_uart_io dut (
    .clk       (clk),
    .resetn    (resetn),
    .ser_rx    (ser_rx),
    .ser_tx    (ser_tx),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .io_sel    (io_sel),
    .io_rdata  (io_rdata),
    .rx_irq    (rx_irq)
  );

  always #5 clk = ~clk;

  // All bus/serial tasks start and end 1 time unit after a rising edge.
  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    mem_read = 1'b1;
    mem_addr = a;
    @(posedge clk); #1;
    mem_read = 1'b0;
    mem_addr = '0;
    d = io_rdata;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] w);
    mem_write = 1'b1;
    mem_addr  = a;
    mem_wdata = w;
    @(posedge clk); #1;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    ser_rx = 1'b0;
    repeat (16) @(posedge clk); #1;
    for (int i = 0; i < 8; i++) begin
      ser_rx = b[i];
      repeat (16) @(posedge clk); #1;
    end
    ser_rx = stop;
    repeat (16) @(posedge clk); #1;
    ser_rx = 1'b1;
  endtask

  task automatic test_reset;
    logic [31:0] d;
    resetn = 1'b0;
    repeat (3) @(posedge clk); #1;
    n_vec++; if (ser_tx !== 1'b1) begin n_err++; $display("FAIL rst_ser_tx: got %b expected 1", ser_tx); end
    n_vec++; if (rx_irq !== 1'b0) begin n_err++; $display("FAIL rst_rx_irq: got %b expected 0", rx_irq); end
    n_vec++; if (io_rdata !== 32'h0) begin n_err++; $display("FAIL rst_io_rdata: got %h expected 0", io_rdata); end
    resetn = 1'b1;
    repeat (3) @(posedge clk); #1;
    mem_addr = IO_ADDR; #1;
    n_vec++; if (io_sel !== 1'b1) begin n_err++; $display("FAIL io_sel_io: got %b expected 1", io_sel); end
    mem_addr = STAT_ADDR; #1;
    n_vec++; if (io_sel !== 1'b1) begin n_err++; $display("FAIL io_sel_stat: got %b expected 1", io_sel); end
    mem_addr = 32'hFFFF_FFFE; #1;
    n_vec++; if (io_sel !== 1'b0) begin n_err++; $display("FAIL io_sel_other: got %b expected 0", io_sel); end
    mem_addr = '0;
    @(posedge clk); #1;
    bus_read(IO_ADDR, d);
    n_vec++; if (d !== 32'h0) begin n_err++; $display("FAIL rst_io_read: got %h expected 0", d); end
    bus_read(STAT_ADDR, d);
    n_vec++; if (d !== 32'h2) begin n_err++; $display("FAIL rst_stat_read: got %h expected 2", d); end
  endtask

  task automatic test_rx_fifo;
    logic [31:0] d;
    logic [7:0]  exp_b [3] = '{8'h33, 8'h34, 8'h0A};
    for (int i = 0; i < 3; i++) send_byte(exp_b[i], 1'b1);
    n_vec++; if (rx_irq !== 1'b1) begin n_err++; $display("FAIL rx_irq_set: got %b expected 1", rx_irq); end
    for (int i = 0; i < 3; i++) begin
      bus_read(IO_ADDR, d);
      n_vec++; if (d !== {24'h0, exp_b[i]}) begin n_err++; $display("FAIL rx_pop%0d: got %h expected %h", i, d, exp_b[i]); end
    end
    n_vec++; if (rx_irq !== 1'b0) begin n_err++; $display("FAIL rx_irq_clear: got %b expected 0", rx_irq); end
    bus_read(IO_ADDR, d);
    n_vec++; if (d !== 32'h0) begin n_err++; $display("FAIL rx_pop_empty: got %h expected 0", d); end
  endtask

  task automatic test_tx_frame;
    logic [31:0] d;
    logic [7:0]  frames [2] = '{8'h41, 8'h42};
    logic        found = 1'b0;
    logic        exp_bit;
    int          pos;
    bus_write(IO_ADDR, 32'hABCD_0041);
    for (int i = 0; i < 50 && !found; i++) begin
      if (ser_tx === 1'b0) found = 1'b1;
      else begin @(posedge clk); #1; end
    end
    n_vec++; if (!found) begin n_err++; $display("FAIL tx_start_timeout: got no start bit expected one within 50 cycles"); end
    if (found) begin
      fork
        begin
          repeat (8) @(posedge clk); #1;
          for (int k = 0; k < 20; k++) begin
            if (k == 10) begin
              repeat (8) @(posedge clk); #1;
              n_vec++; if (ser_tx !== 1'b0) begin n_err++; $display("FAIL tx_back_to_back: got %b expected 0", ser_tx); end
              repeat (8) @(posedge clk); #1;
            end else if (k > 0) begin
              repeat (16) @(posedge clk); #1;
            end
            pos = k % 10;
            exp_bit = (pos == 0) ? 1'b0 : (pos == 9) ? 1'b1 : frames[k / 10][pos - 1];
            n_vec++; if (ser_tx !== exp_bit) begin n_err++; $display("FAIL tx_bit%0d: got %b expected %b", k, ser_tx, exp_bit); end
          end
        end
        begin
          repeat (30) @(posedge clk); #1;
          bus_write(IO_ADDR, 32'h0000_0042);
          bus_read(STAT_ADDR, d);
          n_vec++; if (d !== 32'h0) begin n_err++; $display("FAIL tx_not_ready: got %h expected 0", d); end
          bus_write(IO_ADDR, 32'h0000_0043);
          bus_read(STAT_ADDR, d);
          n_vec++; if (d !== 32'h8) begin n_err++; $display("FAIL tx_overrun_set: got %h expected 8", d); end
          bus_read(STAT_ADDR, d);
          n_vec++; if (d !== 32'h0) begin n_err++; $display("FAIL tx_overrun_clear: got %h expected 0", d); end
        end
      join
      repeat (40) @(posedge clk); #1;
      n_vec++; if (ser_tx !== 1'b1) begin n_err++; $display("FAIL tx_idle_after: got %b expected 1", ser_tx); end
      bus_read(STAT_ADDR, d);
      n_vec++; if (d !== 32'h2) begin n_err++; $display("FAIL tx_ready_again: got %h expected 2", d); end
    end
  endtask

  task automatic test_rx_overrun;
    logic [31:0] d;
    for (int i = 0; i < 5; i++) send_byte(8'h11 + 8'(i), 1'b1);
    bus_read(STAT_ADDR, d);
    n_vec++; if (d !== 32'h7) begin n_err++; $display("FAIL rx_overrun_set: got %h expected 7", d); end
    bus_read(STAT_ADDR, d);
    n_vec++; if (d !== 32'h3) begin n_err++; $display("FAIL rx_overrun_clear: got %h expected 3", d); end
    for (int i = 0; i < 4; i++) begin
      bus_read(IO_ADDR, d);
      n_vec++; if (d !== 32'h11 + 32'(i)) begin n_err++; $display("FAIL ovr_pop%0d: got %h expected %h", i, d, 32'h11 + 32'(i)); end
    end
    bus_read(IO_ADDR, d);
    n_vec++; if (d !== 32'h0) begin n_err++; $display("FAIL ovr_pop_empty: got %h expected 0", d); end
  endtask

  task automatic test_frame_err_glitch;
    logic [31:0] d;
    send_byte(8'h5A, 1'b0);
    repeat (20) @(posedge clk); #1;
    n_vec++; if (rx_irq !== 1'b0) begin n_err++; $display("FAIL ferr_no_push: got %b expected 0", rx_irq); end
    bus_read(STAT_ADDR, d);
    n_vec++; if (d !== 32'h12) begin n_err++; $display("FAIL ferr_stat: got %h expected 12", d); end
    ser_rx = 1'b0;
    repeat (4) @(posedge clk); #1;
    ser_rx = 1'b1;
    repeat (40) @(posedge clk); #1;
    n_vec++; if (rx_irq !== 1'b0) begin n_err++; $display("FAIL glitch_no_push: got %b expected 0", rx_irq); end
    bus_read(STAT_ADDR, d);
    n_vec++; if (d !== 32'h2) begin n_err++; $display("FAIL glitch_stat: got %h expected 2", d); end
  endtask

  task automatic test_full_push_pop;
    logic [31:0] d;
    for (int i = 0; i < 4; i++) send_byte(8'h21 + 8'(i), 1'b1);
    // Stop-bit push lands on the 155th edge after the start bit is driven.
    fork
      send_byte(8'h25, 1'b1);
      begin
        repeat (154) @(posedge clk); #1;
        bus_read(IO_ADDR, d);
      end
    join
    n_vec++; if (d !== 32'h21) begin n_err++; $display("FAIL full_pop_head: got %h expected 21", d); end
    bus_read(STAT_ADDR, d);
    n_vec++; if (d !== 32'h3) begin n_err++; $display("FAIL full_no_overrun: got %h expected 3", d); end
    for (int i = 0; i < 4; i++) begin
      bus_read(IO_ADDR, d);
      n_vec++; if (d !== 32'h22 + 32'(i)) begin n_err++; $display("FAIL full_pop%0d: got %h expected %h", i, d, 32'h22 + 32'(i)); end
    end
    n_vec++; if (rx_irq !== 1'b0) begin n_err++; $display("FAIL full_drained: got %b expected 0", rx_irq); end
  endtask

  task automatic test_reset_mid_frame;
    logic [31:0] d;
    bus_write(IO_ADDR, 32'h0000_0000);
    repeat (40) @(posedge clk); #1;
    n_vec++; if (ser_tx !== 1'b0) begin n_err++; $display("FAIL mid_frame_low: got %b expected 0", ser_tx); end
    #2 resetn = 1'b0;
    #1;
    n_vec++; if (ser_tx !== 1'b1) begin n_err++; $display("FAIL async_reset_tx: got %b expected 1", ser_tx); end
    repeat (2) @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;
    bus_read(STAT_ADDR, d);
    n_vec++; if (d !== 32'h2) begin n_err++; $display("FAIL post_reset_stat: got %h expected 2", d); end
  endtask

  task automatic test_loopback;
    logic [31:0] d;
    bus_write(IO_ADDR, 32'h0000_0055);
    repeat (200) @(posedge clk); #1;
    bus_read(IO_ADDR, d);
    n_vec++; if (d !== 32'h55) begin n_err++; $display("FAIL loopback: got %h expected 55", d); end
  endtask

  initial begin
    test_reset;
`ifdef MIC1_UART_LOOPBACK_EN
    test_loopback;
`else
    test_rx_fifo;
    test_tx_frame;
    test_rx_overrun;
    test_frame_err_glitch;
    test_full_push_pop;
    test_reset_mid_frame;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
